program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 41 ++++
 rtl/program_loader.sv | 216 +++++++++++++++++++++
 tb/tb_program_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Bundle of the byte-stream input and instruction-memory write bus for
// program_loader, plus the processor-hold and completion status lines.
// The slave modport is the loader's view; the master modport is the
// view of the block that feeds the stream and watches the memory bus.
interface program_loader_if #(
    parameter int AW = 10
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  done,
        input  error
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output done,
        output error
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte
// stream and writes the payload into instruction memory while holding the
// processor in reset. The processor is released only after a good checksum.
module program_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Compare the 16-bit length against DEPTH with one spare bit so that
    // DEPTH = 65536 would still compare correctly.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // Running checksum update: the checksum is a plain byte-wise XOR.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t        state_r;
    state_t        state_next_s;

    logic [15:0]   len_r;
    logic [15:0]   cnt_r;
    logic [7:0]    xor_r;

    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [7:0]    mem_wdata_r;

    logic          in_ready_r;
    logic          done_r;
    logic          error_r;
    logic          cpu_hold_r;

    logic          in_ready_s;
    logic          done_s;
    logic          error_s;
    logic          cpu_hold_s;

    logic          xfer_s;
    logic          data_xfer_s;
    logic [15:0]   len_full_s;
    logic          last_byte_s;

    // in_ready is a register decoded from state, so a transfer never
    // depends combinationally on in_valid.
    assign xfer_s      = bus.in_valid & in_ready_r;
    assign data_xfer_s = xfer_s & (state_r == ST_DATA);
    assign len_full_s  = {len_r[15:8], bus.in_data};
    assign last_byte_s = (cnt_r == (len_r - 16'd1));

    // State register; reset wins over any byte offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LEN_HI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode of the stream parser.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LEN_HI: begin
                if (xfer_s) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    if (len_full_s == 16'd0) begin
                        state_next_s = ST_CHECK;
                    end else if ({1'b0, len_full_s} > DEPTH_W) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DATA: begin
                if (xfer_s && last_byte_s) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    if (bus.in_data == xor_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            ST_ERR: begin
                state_next_s = ST_ERR;
            end
            default: begin
                // An illegal encoding is treated as a failed load.
                state_next_s = ST_ERR;
            end
        endcase
    end

    // Status outputs decoded from the next state so the registered copies
    // line up with the state register (done and cpu_hold change together).
    always_comb begin
        in_ready_s = 1'b1;
        done_s     = 1'b0;
        error_s    = 1'b0;
        cpu_hold_s = 1'b1;
        case (state_next_s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: begin
                in_ready_s = 1'b1;
                done_s     = 1'b0;
                error_s    = 1'b0;
                cpu_hold_s = 1'b1;
            end
            ST_DONE: begin
                in_ready_s = 1'b0;
                done_s     = 1'b1;
                error_s    = 1'b0;
                cpu_hold_s = 1'b0;
            end
            ST_ERR: begin
                in_ready_s = 1'b0;
                done_s     = 1'b0;
                error_s    = 1'b1;
                cpu_hold_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                done_s     = 1'b0;
                error_s    = 1'b1;
                cpu_hold_s = 1'b1;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            cpu_hold_r <= 1'b1;
        end else begin
            in_ready_r <= in_ready_s;
            done_r     <= done_s;
            error_r    <= error_s;
            cpu_hold_r <= cpu_hold_s;
        end
    end

    // Length capture, payload counter, running checksum and the one-cycle
    // write pipeline; reset drops any write that was about to be issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r       <= 16'd0;
            cnt_r       <= 16'd0;
            xor_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'd0;
        end else begin
            mem_we_r <= data_xfer_s;
            if (data_xfer_s) begin
                mem_addr_r  <= cnt_r[AW-1:0];
                mem_wdata_r <= bus.in_data;
                cnt_r       <= cnt_r + 16'd1;
                xor_r       <= xor_fold(xor_r, bus.in_data);
            end else if (xfer_s && (state_r == ST_LEN_HI)) begin
                len_r[15:8] <= bus.in_data;
            end else if (xfer_s && (state_r == ST_LEN_LO)) begin
                len_r[7:0]  <= bus.in_data;
                cnt_r       <= 16'd0;
                xor_r       <= 8'd0;
            end else begin
                cnt_r       <= cnt_r;
                xor_r       <= xor_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
    assign bus.cpu_hold  = cpu_hold_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table for the
// short streams, plus hand-written sequences for the stalled stream and
// the full-depth load.
module tb_program_loader;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    program_loader_if #(.AW(10)) bus();

    program_loader #(.DEPTH(1024), .AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wd;
        logic       dn;
        logic       er;
        logic       hold;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] strm [0:6];
    logic [9:0] wr_addr [0:7];
    logic [7:0] wr_data [0:7];

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic rdy, input logic we, input logic [9:0] a,
                       input logic [7:0] wd, input logic dn, input logic er,
                       input logic hold);
        vec_t e;
        e.rst = r; e.vld = v; e.dat = d; e.rdy = rdy; e.we = we; e.addr = a;
        e.wd = wd; e.dn = dn; e.er = er; e.hold = hold;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs, then let the edge happen and settle.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset        = r;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [22:0] act_v;
        logic [22:0] exp_v;
        int          idx;
        int          nwr;
        int          bad;
        logic [9:0]  lasta;
        logic [7:0]  xs;
        logic [7:0]  b;

        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Good 4-byte load; byte offered during reset is discarded.
        add(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 10'd0, 8'h3C, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 10'd1, 8'h08, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 10'd2, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 10'd3, 8'h01, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h35, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Oversize length 1025 -> ERR, no writes, stays there.
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        // Bad checksum: AA^55 = FF, 00 sent.
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 10'd0, 8'hAA, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 10'd1, 8'h55, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        // Zero-length load with a stall in CHECK.
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Reset mid-DATA (byte offered with reset is dropped), then reload.
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 10'd0, 8'h11, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 10'd1, 8'h22, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 10'd0, 8'h7E, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].dat);
            act_v = {bus.in_ready, bus.mem_we, bus.done, bus.error, bus.cpu_hold,
                     tbl[i].we ? bus.mem_addr : 10'd0, tbl[i].we ? bus.mem_wdata : 8'd0};
            exp_v = {tbl[i].rdy, tbl[i].we, tbl[i].dn, tbl[i].er, tbl[i].hold,
                     tbl[i].addr, tbl[i].wd};
            chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
        end

        // Same good stream with in_valid toggling every cycle.
        strm[0] = 8'h00; strm[1] = 8'h04; strm[2] = 8'h3C; strm[3] = 8'h08;
        strm[4] = 8'h00; strm[5] = 8'h01; strm[6] = 8'h35;
        step(1'b1, 1'b0, 8'h00);
        idx = 0;
        nwr = 0;
        for (int c = 0; c < 40 && idx < 7; c++) begin
            if ((c % 2) == 0) begin
                step(1'b0, 1'b1, strm[idx]);
                idx++;
            end else begin
                step(1'b0, 1'b0, 8'hEE);
            end
            if (bus.mem_we) begin
                if (nwr < 8) begin
                    wr_addr[nwr] = bus.mem_addr;
                    wr_data[nwr] = bus.mem_wdata;
                end
                nwr++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.mem_we) nwr++;
        end
        chk("toggle_nwr", 32'(nwr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("toggle_wr%0d", k),
                32'({wr_addr[k], wr_data[k]}), 32'({10'(k), strm[k + 2]}));
        end
        chk("toggle_done", 32'({bus.done, bus.cpu_hold, bus.error}), 32'd4);

        // Full-depth load: 1024 bytes, addresses 0..1023, correct checksum.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h04);
        step(1'b0, 1'b1, 8'h00);
        xs    = 8'h00;
        nwr   = 0;
        bad   = 0;
        lasta = 10'd0;
        for (int i = 0; i < 1024; i++) begin
            b = 8'(i) ^ 8'h5A;
            step(1'b0, 1'b1, b);
            xs = xs ^ b;
            if (bus.mem_we) begin
                if ((bus.mem_addr != 10'(i)) || (bus.mem_wdata != b)) bad++;
                lasta = bus.mem_addr;
                nwr++;
            end
        end
        chk("full_ready_before_cksum", 32'({bus.in_ready, bus.done}), 32'd2);
        step(1'b0, 1'b1, xs);
        if (bus.mem_we) nwr++;
        chk("full_nwr", 32'(nwr), 32'd1024);
        chk("full_bad", 32'(bad), 32'd0);
        chk("full_last_addr", 32'(lasta), 32'd1023);
        chk("full_done", 32'({bus.done, bus.cpu_hold, bus.error}), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
